// File: rtl/str_seq_ctrl.sv
// str_seq_ctrl: sends a short packed-string pattern REPEAT times over a
// valid/ready byte stream, with GAP idle cycles between repetitions.
//
// Handshake: tx_valid/tx_data are driven from registered state only. Once
// tx_valid is high, tx_valid and tx_data stay unchanged until the cycle
// where tx_ready is also high. That cycle is the one transfer of the
// current char.
module str_seq_ctrl #(
  parameter logic [23:0] PATTERN = "FOO",
  parameter int          REPEAT  = 2,
  parameter int          GAP     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rep_cnt
);

  // Number of chars from the most significant nonzero byte down to byte 0.
  function automatic int calc_nchars(input logic [23:0] p);
    int n;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (p[i*8 +: 8] != 8'd0) n = i + 1;
    end
    return n;
  endfunction

  // A repeat count below one still sends the pattern once.
  function automatic int calc_nrep(input int r);
    return (r >= 1) ? r : 1;
  endfunction

  localparam int         NCHARS    = calc_nchars(PATTERN);
  localparam int         NREP      = calc_nrep(REPEAT);
  localparam logic [1:0] FIRST_IDX = (NCHARS > 0) ? 2'(NCHARS - 1) : 2'd0;
  localparam logic [8:0] NREP9     = 9'(NREP);
  localparam logic [31:0] GAP_LAST = (GAP > 0) ? 32'(GAP - 1) : 32'd0;

  // rep_cnt is 8 bits wide, so larger repeat counts cannot be reported.
  generate
    if (NREP > 255) begin : g_nrep_too_big
      $error("str_seq_ctrl: REPEAT must not exceed 255");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;     // byte index of the current char, counts down
  logic [7:0]  rep_q, rep_d;     // completed repetitions
  logic [31:0] gap_q, gap_d;     // idle cycles already spent in ST_GAP
  logic [7:0]  cur_byte;

  // Select the pattern byte addressed by the char index.
  always_comb begin
    cur_byte = 8'd0;
    case (idx_q)
      2'd0:    cur_byte = PATTERN[7:0];
      2'd1:    cur_byte = PATTERN[15:8];
      default: cur_byte = PATTERN[23:16];
    endcase
  end

  // State register and datapath registers, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      rep_q   <= 8'd0;
      gap_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
    end
  end

  // Next-state logic and Moore outputs.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rep_d    = rep_q;
    gap_d    = gap_q;
    tx_valid = 1'b0;
    tx_data  = 8'd0;
    busy     = 1'b1;
    done     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          rep_d = 8'd0;
          idx_d = FIRST_IDX;
          gap_d = 32'd0;
          if (NCHARS == 0) state_d = ST_DONE;
          else             state_d = ST_SEND;
        end
      end

      ST_SEND: begin
        tx_valid = 1'b1;
        tx_data  = cur_byte;
        if (tx_ready) begin
          if (idx_q == 2'd0) begin
            // Last char of this repetition has just been accepted.
            rep_d = rep_q + 8'd1;
            idx_d = FIRST_IDX;
            if (({1'b0, rep_q} + 9'd1) < NREP9) begin
              if (GAP == 0) begin
                state_d = ST_SEND;
              end else begin
                state_d = ST_GAP;
                gap_d   = 32'd0;
              end
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            idx_d = idx_q - 2'd1;
          end
        end
      end

      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_SEND;
        else                   gap_d   = gap_q + 32'd1;
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign rep_cnt = rep_q;

endmodule

// File: tb/tb_str_seq_ctrl.sv
// Bench for str_seq_ctrl: six parameterisations side by side, each checked
// against an expected char queue built from the pattern and repeat rules.
module tb_str_seq_ctrl;

  localparam int NI = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [NI-1:0] start_v;
  logic [NI-1:0] ready_v;
  logic [NI-1:0] valid_v;
  logic [NI-1:0] busy_v;
  logic [NI-1:0] done_v;
  logic [7:0]    data_v [NI];
  logic [7:0]    rep_v  [NI];

  int checks = 0;
  int errors = 0;

  logic [23:0] pat_a [NI];
  int          rep_a [NI];
  int          gap_a [NI];

  // Clock.
  always #5 clk = ~clk;

  str_seq_ctrl #(.PATTERN("FOO"), .REPEAT(2), .GAP(1)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .tx_ready(ready_v[0]),
    .tx_valid(valid_v[0]), .tx_data(data_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .rep_cnt(rep_v[0]));
  str_seq_ctrl #(.PATTERN("BAZ"), .REPEAT(1), .GAP(1)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .tx_ready(ready_v[1]),
    .tx_valid(valid_v[1]), .tx_data(data_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .rep_cnt(rep_v[1]));
  str_seq_ctrl #(.PATTERN(24'h000041), .REPEAT(3), .GAP(0)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .tx_ready(ready_v[2]),
    .tx_valid(valid_v[2]), .tx_data(data_v[2]), .busy(busy_v[2]),
    .done(done_v[2]), .rep_cnt(rep_v[2]));
  str_seq_ctrl #(.PATTERN(24'h000000), .REPEAT(2), .GAP(1)) u3 (
    .clk(clk), .rst(rst), .start(start_v[3]), .tx_ready(ready_v[3]),
    .tx_valid(valid_v[3]), .tx_data(data_v[3]), .busy(busy_v[3]),
    .done(done_v[3]), .rep_cnt(rep_v[3]));
  str_seq_ctrl #(.PATTERN(24'h004142), .REPEAT(0), .GAP(2)) u4 (
    .clk(clk), .rst(rst), .start(start_v[4]), .tx_ready(ready_v[4]),
    .tx_valid(valid_v[4]), .tx_data(data_v[4]), .busy(busy_v[4]),
    .done(done_v[4]), .rep_cnt(rep_v[4]));
  str_seq_ctrl #(.PATTERN("XYZ"), .REPEAT(3), .GAP(3)) u5 (
    .clk(clk), .rst(rst), .start(start_v[5]), .tx_ready(ready_v[5]),
    .tx_valid(valid_v[5]), .tx_data(data_v[5]), .busy(busy_v[5]),
    .done(done_v[5]), .rep_cnt(rep_v[5]));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int k, input string tag);
    chk({tag, "_valid"}, 32'(valid_v[k]), 32'd0);
    chk({tag, "_data"},  32'(data_v[k]),  32'd0);
    chk({tag, "_busy"},  32'(busy_v[k]),  32'd0);
    chk({tag, "_done"},  32'(done_v[k]),  32'd0);
    chk({tag, "_rep"},   32'(rep_v[k]),   32'd0);
  endtask

  // Chars in the pattern: from the highest nonzero byte down to byte 0.
  function automatic int model_nchars(input logic [23:0] p);
    for (int i = 2; i >= 0; i--) begin
      if (p[i*8 +: 8] != 8'd0) return i + 1;
    end
    return 0;
  endfunction

  // One start on instance k, compared cycle by cycle to the reference.
  // mode 0: always ready; 1: random ready; 2: ready low 3 cycles on 2nd char.
  task automatic run_seq(input int k, input int mode, input bit hold);
    logic [7:0] exp_q [$];
    logic [7:0] first_c;
    int n, nrep, gap_left, in_rep, reps, stall, cyc;
    bit rdy, fin;
    n    = model_nchars(pat_a[k]);
    nrep = (rep_a[k] < 1) ? 1 : rep_a[k];
    for (int r = 0; r < nrep; r++)
      for (int c = n - 1; c >= 0; c--) exp_q.push_back(pat_a[k][c*8 +: 8]);
    first_c  = (n > 0) ? pat_a[k][(n-1)*8 +: 8] : 8'd0;
    gap_left = 0; in_rep = 0; reps = 0; stall = 0; cyc = 0; fin = 1'b0;

    chk("pre_busy", 32'(busy_v[k]), 32'd0);
    start_v[k] = 1'b1;
    tick();
    if (!hold) start_v[k] = 1'b0;

    while (!fin && cyc < 200) begin
      if (exp_q.size() > 0) begin
        chk("rep_cnt", 32'(rep_v[k]), 32'(reps));
        chk("busy", 32'(busy_v[k]), 32'd1);
        chk("done_early", 32'(done_v[k]), 32'd0);
        if (gap_left > 0) begin
          chk("gap_valid", 32'(valid_v[k]), 32'd0);
          gap_left--;
          rdy = ($urandom_range(0, 1) != 0);
        end else begin
          chk("valid", 32'(valid_v[k]), 32'd1);
          chk("data", 32'(data_v[k]), 32'(exp_q[0]));
          if (mode == 0) rdy = 1'b1;
          else if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
          else begin
            rdy = !(in_rep == 1 && stall < 3);
            if (!rdy) stall++;
          end
          if (rdy) begin
            void'(exp_q.pop_front());
            in_rep++;
            if (in_rep == n) begin
              in_rep = 0;
              reps++;
              if (exp_q.size() > 0) gap_left = gap_a[k];
            end
          end
        end
        ready_v[k] = rdy;
        tick();
        cyc++;
      end else begin
        chk("done", 32'(done_v[k]), 32'd1);
        chk("done_valid", 32'(valid_v[k]), 32'd0);
        chk("done_busy", 32'(busy_v[k]), 32'd1);
        chk("done_rep", 32'(rep_v[k]), 32'(reps));
        ready_v[k] = ($urandom_range(0, 1) != 0);
        tick();
        ready_v[k] = 1'b0;
        chk("post_done", 32'(done_v[k]), 32'd0);
        chk("post_busy", 32'(busy_v[k]), 32'd0);
        chk("post_valid", 32'(valid_v[k]), 32'd0);
        chk("post_data", 32'(data_v[k]), 32'd0);
        chk("post_rep", 32'(rep_v[k]), 32'(nrep_or_zero(n, nrep)));
        fin = 1'b1;
      end
    end
    if (!fin) chk("timeout", 32'd0, 32'd1);

    if (hold && fin) begin
      // start stayed high through DONE and IDLE: next sequence begins now.
      tick();
      chk("restart_busy", 32'(busy_v[k]), 32'd1);
      chk("restart_valid", 32'(valid_v[k]), 32'd1);
      chk("restart_data", 32'(data_v[k]), 32'(first_c));
      chk("restart_rep", 32'(rep_v[k]), 32'd0);
      start_v[k] = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
    end
  endtask

  // Repetitions completed by a finished sequence: none when there is no char.
  function automatic int nrep_or_zero(input int n, input int nrep);
    return (n == 0) ? 0 : nrep;
  endfunction

  initial begin
    pat_a[0] = "FOO";      rep_a[0] = 2; gap_a[0] = 1;
    pat_a[1] = "BAZ";      rep_a[1] = 1; gap_a[1] = 1;
    pat_a[2] = 24'h000041; rep_a[2] = 3; gap_a[2] = 0;
    pat_a[3] = 24'h000000; rep_a[3] = 2; gap_a[3] = 1;
    pat_a[4] = 24'h004142; rep_a[4] = 0; gap_a[4] = 2;
    pat_a[5] = "XYZ";      rep_a[5] = 3; gap_a[5] = 3;

    rst = 1'b1;
    start_v = '0;
    ready_v = '0;
    repeat (3) tick();
    // Reset has priority over start and ready.
    start_v = '1;
    ready_v = '1;
    tick();
    start_v = '0;
    ready_v = '0;
    rst = 1'b0;
    for (int k = 0; k < NI; k++) chk_idle(k, "reset");

    // Directed runs per configuration.
    run_seq(0, 0, 1'b0);
    run_seq(1, 2, 1'b0);
    run_seq(2, 0, 1'b0);
    run_seq(3, 0, 1'b0);
    run_seq(4, 0, 1'b0);
    run_seq(5, 0, 1'b0);

    // Random backpressure on random instances.
    for (int t = 0; t < 10; t++) run_seq(int'($urandom_range(0, NI - 1)), 1, 1'b0);

    // Reset while the second 'O' is pending.
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    ready_v[0] = 1'b1;
    tick();
    tick();
    chk("mid_data", 32'(data_v[0]), 32'h4f);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ready_v[0] = 1'b0;
    chk_idle(0, "mid_rst");
    run_seq(0, 0, 1'b0);

    // start held high: back-to-back sequences.
    run_seq(0, 0, 1'b1);
    run_seq(5, 1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
